// File: rtl/pacman_map_writer.sv
// pacman_map_writer: moves Pac-Man on the game map by erasing the vacated
// cell and drawing the new one through an arbitrated map-RAM write port.
module pacman_map_writer #(
  parameter int                MAP_W       = 40,
  parameter int                MAP_H       = 30,
  parameter int                ADDR_W      = 11,
  parameter int                CELL_W      = 2,
  parameter logic [CELL_W-1:0] EMPTY_CODE  = '0,
  parameter logic [CELL_W-1:0] PACMAN_CODE = 2'b11
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [5:0]        curr_pacman_x,
  input  logic [4:0]        curr_pacman_y,
  input  logic [5:0]        next_pacman_x,
  input  logic [4:0]        next_pacman_y,
  input  logic              ram_gnt,
  output logic              ram_req,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CELL_W-1:0] ram_wr_data,
  output logic              done,
  output logic              busy,
  output logic              oob_err,
  output logic [15:0]       move_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ERASE,
    DRAW,
    DONE
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] curr_x_q, next_x_q;
  logic [4:0] curr_y_q, next_y_q;
  logic       curr_ok_q, next_ok_q;
  logic       move_pending;
  logic       curr_in_range, next_in_range;

  // y*MAP_W + x as a constant-coefficient shift-add sum, no multiplier needed
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
    logic [31:0] acc;
    acc = 32'(x);
    for (int unsigned i = 0; i < 16; i++) begin
      if (((MAP_W >> i) & 1) != 0)
        acc = acc + (32'(y) << i);
    end
    return acc[ADDR_W-1:0];
  endfunction

  assign move_pending  = {next_pacman_x, next_pacman_y} != {curr_pacman_x, curr_pacman_y};
  assign curr_in_range = (int'(curr_pacman_x) < MAP_W) && (int'(curr_pacman_y) < MAP_H);
  assign next_in_range = (int'(next_pacman_x) < MAP_W) && (int'(next_pacman_y) < MAP_H);

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; the write strobe is combinational so it
  // can never be high in a cycle where the grant is low
  always_comb begin
    state_nxt = state;
    ram_req   = 1'b0;
    ram_wr_en = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (move_pending) state_nxt = REQ;
      end
      REQ: begin
        ram_req = 1'b1;
        if (ram_gnt) state_nxt = ERASE;
      end
      ERASE: begin
        ram_req = 1'b1;
        if (ram_gnt) begin
          ram_wr_en = curr_ok_q;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        ram_req = 1'b1;
        if (ram_gnt) begin
          ram_wr_en = next_ok_q;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coordinate latches, error flag and move counter
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      curr_x_q   <= '0;
      curr_y_q   <= '0;
      next_x_q   <= '0;
      next_y_q   <= '0;
      curr_ok_q  <= 1'b0;
      next_ok_q  <= 1'b0;
      oob_err    <= 1'b0;
      move_count <= '0;
    end else begin
      if (state == IDLE && move_pending) begin
        curr_x_q  <= curr_pacman_x;
        curr_y_q  <= curr_pacman_y;
        next_x_q  <= next_pacman_x;
        next_y_q  <= next_pacman_y;
        curr_ok_q <= curr_in_range;
        next_ok_q <= next_in_range;
        if (!curr_in_range || !next_in_range) oob_err <= 1'b1;
      end
      if (state == DONE && move_count != '1) move_count <= move_count + 16'd1;
    end
  end

  // Address/data are loaded one state ahead so they are valid with the strobe
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else if (state == REQ && ram_gnt) begin
      ram_addr    <= cell_addr(curr_x_q, curr_y_q);
      ram_wr_data <= EMPTY_CODE;
    end else if (state == ERASE && ram_gnt) begin
      ram_addr    <= cell_addr(next_x_q, next_y_q);
      ram_wr_data <= PACMAN_CODE;
    end
  end

endmodule

// File: tb/tb_pacman_map_writer.sv
// Self-checking bench for pacman_map_writer: expected RAM writes are queued
// when a move is driven and popped by a monitor as the DUT strobes them.
module tb_pacman_map_writer;

  logic        CLOCK_50;
  logic        reset;
  logic [5:0]  cx, nx;
  logic [4:0]  cy, ny;
  logic        ram_gnt;
  logic        ram_req, ram_wr_en, done, busy, oob_err;
  logic [10:0] ram_addr;
  logic [1:0]  ram_wr_data;
  logic [15:0] move_count;

  typedef struct {
    logic [10:0] a;
    logic [1:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [15:0] exp_mc = 0;

  pacman_map_writer #(
    .MAP_W (40),
    .MAP_H (30),
    .ADDR_W(11),
    .CELL_W(2)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .curr_pacman_x(cx),
    .curr_pacman_y(cy),
    .next_pacman_x(nx),
    .next_pacman_y(ny),
    .ram_gnt      (ram_gnt),
    .ram_req      (ram_req),
    .ram_wr_en    (ram_wr_en),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .done         (done),
    .busy         (busy),
    .oob_err      (oob_err),
    .move_count   (move_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [10:0] exp_addr(input int x, input int y);
    return 11'(y * 40 + x);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic push_wr(input int x, input int y, input logic [1:0] d);
    wr_t e;
    e.a = exp_addr(x, y);
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must be granted and match the scoreboard
  always @(negedge CLOCK_50) begin : mon
    wr_t e;
    if (reset === 1'b1 && done === 1'b1) done_cnt++;
    if (reset === 1'b1 && ram_wr_en === 1'b1) begin
      checks++;
      if (ram_gnt !== 1'b1) begin
        errors++;
        $display("FAIL wr_en_without_gnt: gnt=%b required 1", ram_gnt);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%b, none expected", ram_addr, ram_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.a || ram_wr_data !== e.d) begin
          errors++;
          $display("FAIL write_data: addr=%0d data=%b required addr=%0d data=%b",
                   ram_addr, ram_wr_data, e.a, e.d);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; cx = 20; cy = 20; nx = 20; ny = 20; ram_gnt = 1'b1;
    #25;
    checks++;
    if ({ram_req, ram_wr_en, ram_addr, ram_wr_data, done, busy, oob_err, move_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {ram_req, ram_wr_en, ram_addr, ram_wr_data, done, busy, oob_err, move_count});
    end
    @(posedge CLOCK_50); #1 reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLOCK_50);
      checks++;
      if ({busy, ram_req, done, ram_wr_en} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet: busy/req/done/wr=%b required 0000 at cycle %0d",
                 {busy, ram_req, done, ram_wr_en}, k);
      end
    end
  endtask

  task automatic test_basic_move();
    @(posedge CLOCK_50); #1;
    cx = 20; cy = 20; nx = 20; ny = 21; ram_gnt = 1'b1;
    push_wr(20, 20, 2'b00);
    push_wr(20, 21, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLOCK_50); #1 ram_gnt = 1'b1;
      @(negedge CLOCK_50);
      checks++;
      if (ram_wr_en !== (k == 2 || k == 3)) begin
        errors++;
        $display("FAIL basic_wr_en: got %b required %b at cycle %0d", ram_wr_en, (k == 2 || k == 3), k);
      end
      checks++;
      if (done !== (k == 4) || busy !== (k <= 4)) begin
        errors++;
        $display("FAIL basic_done_busy: done=%b busy=%b required %b %b at cycle %0d",
                 done, busy, (k == 4), (k <= 4), k);
      end
      if (k == 4) begin cx = nx; cy = ny; exp_mc = sat_inc(exp_mc); end
    end
    checks++;
    if (move_count !== exp_mc || oob_err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_end: count=%0d oob=%b pending=%0d required %0d 0 0",
               move_count, oob_err, exp_q.size(), exp_mc);
    end
  endtask

  task automatic test_gnt_stall();
    @(posedge CLOCK_50); #1;
    cx = 20; cy = 20; nx = 20; ny = 21;
    push_wr(20, 20, 2'b00);
    push_wr(20, 21, 2'b11);
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLOCK_50); #1 ram_gnt = !(k <= 3 || k == 6 || k == 7);
      @(negedge CLOCK_50);
      checks++;
      if (ram_wr_en !== (k == 5 || k == 8)) begin
        errors++;
        $display("FAIL stall_wr_en: got %b required %b at cycle %0d", ram_wr_en, (k == 5 || k == 8), k);
      end
      checks++;
      if (done !== (k == 9) || ram_req !== (k <= 8)) begin
        errors++;
        $display("FAIL stall_done_req: done=%b req=%b required %b %b at cycle %0d",
                 done, ram_req, (k == 9), (k <= 8), k);
      end
      if (k == 9) begin cx = nx; cy = ny; exp_mc = sat_inc(exp_mc); end
    end
    checks++;
    if (move_count !== exp_mc || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_end: count=%0d pending=%0d required %0d 0", move_count, exp_q.size(), exp_mc);
    end
  endtask

  task automatic test_oob();
    @(posedge CLOCK_50); #1;
    cx = 0; cy = 0; nx = 0; ny = 31; ram_gnt = 1'b1;
    push_wr(0, 0, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLOCK_50); #1;
      @(negedge CLOCK_50);
      checks++;
      if (ram_wr_en !== (k == 2) || done !== (k == 4) || oob_err !== 1'b1) begin
        errors++;
        $display("FAIL oob_seq: wr=%b done=%b oob=%b required %b %b 1 at cycle %0d",
                 ram_wr_en, done, oob_err, (k == 2), (k == 4), k);
      end
      if (k == 4) begin cx = nx; cy = ny; exp_mc = sat_inc(exp_mc); end
    end
    checks++;
    if (move_count !== exp_mc) begin
      errors++;
      $display("FAIL oob_count: got %0d required %0d", move_count, exp_mc);
    end
    // an in-range move afterwards must still write and leave the flag set
    @(posedge CLOCK_50); #1;
    cx = 0; cy = 0; nx = 1; ny = 0;
    push_wr(0, 0, 2'b00);
    push_wr(1, 0, 2'b11);
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLOCK_50); #1;
      @(negedge CLOCK_50);
      checks++;
      if (done !== (k == 4) || oob_err !== 1'b1) begin
        errors++;
        $display("FAIL oob_sticky: done=%b oob=%b required %b 1 at cycle %0d", done, oob_err, (k == 4), k);
      end
      if (k == 4) begin cx = nx; cy = ny; exp_mc = sat_inc(exp_mc); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge CLOCK_50); #1;
    cx = 20; cy = 20; nx = 20; ny = 21;
    push_wr(20, 20, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLOCK_50); #1 ram_gnt = (k != 3);
      @(negedge CLOCK_50);
    end
    checks++;
    if (busy !== 1'b1 || ram_req !== 1'b1 || ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_draw: busy=%b req=%b wr=%b required 1 1 0", busy, ram_req, ram_wr_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ram_req, ram_wr_en, ram_addr, ram_wr_data, done, busy, oob_err, move_count} !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: got %h required 0",
               {ram_req, ram_wr_en, ram_addr, ram_wr_data, done, busy, oob_err, move_count});
    end
    exp_mc = 0;
    ram_gnt = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge CLOCK_50);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_held_reset: done=%b busy=%b required 0 0", done, busy);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_erase_missing: pending=%0d required 0", exp_q.size());
    end
    push_wr(20, 20, 2'b00);
    push_wr(20, 21, 2'b11);
    @(posedge CLOCK_50); #1 reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLOCK_50); #1;
      @(negedge CLOCK_50);
      checks++;
      if (ram_wr_en !== (k == 2 || k == 3) || done !== (k == 4)) begin
        errors++;
        $display("FAIL mid_restart: wr=%b done=%b required %b %b at cycle %0d",
                 ram_wr_en, done, (k == 2 || k == 3), (k == 4), k);
      end
      if (k == 4) begin cx = nx; cy = ny; exp_mc = sat_inc(exp_mc); end
    end
    checks++;
    if (move_count !== exp_mc) begin
      errors++;
      $display("FAIL mid_count: got %0d required %0d", move_count, exp_mc);
    end
  endtask

  task automatic test_saturation();
    @(posedge CLOCK_50); #1;
    force dut.move_count = 16'hFFFE;
    #1 release dut.move_count;
    exp_mc = 16'hFFFE;
    for (int m = 0; m < 2; m++) begin
      @(posedge CLOCK_50); #1;
      nx = 20;
      ny = (cy == 21) ? 5'd20 : 5'd21;
      push_wr(int'(cx), int'(cy), 2'b00);
      push_wr(int'(nx), int'(ny), 2'b11);
      for (int k = 1; k <= 6; k++) begin
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (done !== (k == 4)) begin
          errors++;
          $display("FAIL sat_done: got %b required %b at cycle %0d move %0d", done, (k == 4), k, m);
        end
        if (k == 4) begin cx = nx; cy = ny; exp_mc = sat_inc(exp_mc); end
      end
      checks++;
      if (move_count !== exp_mc) begin
        errors++;
        $display("FAIL sat_count: got %h required %h move %0d", move_count, exp_mc, m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_gnt_stall();
    test_oob();
    test_reset_mid();
    test_saturation();
    repeat (4) @(negedge CLOCK_50);
    checks++;
    if (exp_q.size() != 0 || done_cnt != 7) begin
      errors++;
      $display("FAIL final_totals: pending=%0d dones=%0d required 0 7", exp_q.size(), done_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
